csel_pipe_addsub: RTL and testbench

- Parametrised, pipelined successor of the 32-bit combinational carry-select adder.
- Datapath is split into GROUP-bit carry-select groups. Each group computes sum-with-carry-0 and sum-with-carry-1 in parallel, then selects on the incoming carry.
- Groups are partitioned across STAGES register stages, with a valid/ready handshake and add/subtract mode.
- Sits in the execute path as the multi-cycle ALU adder for wide operands where a single-cycle carry chain misses timing.

---
 rtl/csel_pipe_addsub_pkg.sv | 25 ++
 rtl/csel_pipe_addsub_group.sv | 28 ++
 rtl/csel_pipe_addsub.sv | 177 +++++++++++++++++
 tb/tb_csel_pipe_addsub.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pipe_addsub_pkg.sv
// csel_pkg: sizing helpers and shared records for the pipelined carry-select adder.
// Group-to-stage split: every stage takes NG/STAGES groups; the last stage also takes the remainder.
package csel_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } csel_flags_t;

    function automatic int unsigned calc_ng(input int unsigned width, input int unsigned group);
        return width / group;
    endfunction

    function automatic int unsigned stage_lo(input int unsigned s, input int unsigned ng,
                                             input int unsigned stages);
        return s * (ng / stages);
    endfunction

    function automatic int unsigned stage_hi(input int unsigned s, input int unsigned ng,
                                             input int unsigned stages);
        return (s == stages - 1) ? ng : (s + 1) * (ng / stages);
    endfunction

endpackage

// File: rtl/csel_pipe_addsub_group.sv
// csel_group: one GROUP-bit carry-select slice; RIPPLE=1 builds a plain adder for the
// least significant group, which sees the carry-in directly.
module csel_group #(
    parameter int unsigned GROUP  = 4,
    parameter bit          RIPPLE = 1'b0
) (
    input  logic [GROUP-1:0] a_i,
    input  logic [GROUP-1:0] b_i,
    input  logic             sel_i,
    output logic [GROUP-1:0] s_o,
    output logic             c_o
);

    if (RIPPLE) begin : g_ripple
        always_comb begin
            {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{GROUP{1'b0}}, sel_i};
        end
    end else begin : g_select
        logic [GROUP:0] sum0, sum1;

        always_comb begin
            sum0 = {1'b0, a_i} + {1'b0, b_i};
            sum1 = {1'b0, a_i} + {1'b0, b_i} + {{GROUP{1'b0}}, 1'b1};
            {c_o, s_o} = sel_i ? sum1 : sum0;
        end
    end

endmodule

// File: rtl/csel_pipe_addsub.sv
// csel_pipe_addsub: STAGES-deep pipelined carry-select add/subtract with valid/ready.
// Optional CSEL_PIPE_SAT_EN adds a Sat input that clamps signed-overflowed results.
module csel_pipe_addsub
    import csel_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
`ifdef CSEL_PIPE_SAT_EN
    input  logic             Sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned NG = calc_ng(WIDTH, GROUP);

    logic [STAGES-1:0] v_q, v_up, ld;

    // Load enables chain back from the output so a drained slot frees its upstream neighbour
    // in the same cycle.
    always_comb begin
        logic r;
        v_up    = '0;
        ld      = '0;
        v_up[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) v_up[k] = v_q[k-1];
        r = !v_q[STAGES-1] || out_ready;
        ld[STAGES-1] = r;
        for (int unsigned k = 1; k < STAGES; k++) begin
            r = !v_q[STAGES-1-k] || r;
            ld[STAGES-1-k] = r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) if (ld[k]) v_q[k] <= v_up[k];
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int unsigned LB = stage_lo(s, NG, STAGES) * GROUP;
        localparam int unsigned HB = stage_hi(s, NG, STAGES) * GROUP;
        localparam int unsigned SW = HB - LB;
        localparam int unsigned SG = SW / GROUP;

        logic [SW-1:0] a_s, b_s, sum_s;
        logic [HB-1:0] y_full;
        logic [SG:0]   cc;
        logic          c_s;
`ifdef CSEL_PIPE_SAT_EN
        logic          sat_s;
`endif

        // Stage 0 reads the ports; later stages read the previous stage's registers,
        // where B is already inverted for subtract and the carry is a single flop.
        if (s == 0) begin : g_src
            assign a_s    = A[HB-1:0];
            assign b_s    = Sub ? ~B[HB-1:0] : B[HB-1:0];
            assign c_s    = Sub | Cin;
            assign y_full = sum_s;
`ifdef CSEL_PIPE_SAT_EN
            assign sat_s  = Sat;
`endif
        end else begin : g_src
            assign a_s    = stg[s-1].g_reg.a_q[SW-1:0];
            assign b_s    = stg[s-1].g_reg.b_q[SW-1:0];
            assign c_s    = stg[s-1].g_reg.c_q;
            assign y_full = {sum_s, stg[s-1].g_reg.y_q};
`ifdef CSEL_PIPE_SAT_EN
            assign sat_s  = stg[s-1].g_reg.sat_q;
`endif
        end

        assign cc[0] = c_s;
        for (genvar g = 0; g < SG; g++) begin : grp
            csel_group #(
                .GROUP  (GROUP),
                .RIPPLE (s == 0 && g == 0)
            ) u_grp (
                .a_i   (a_s[g*GROUP +: GROUP]),
                .b_i   (b_s[g*GROUP +: GROUP]),
                .sel_i (cc[g]),
                .s_o   (sum_s[g*GROUP +: GROUP]),
                .c_o   (cc[g+1])
            );
        end

        if (s < STAGES - 1) begin : g_reg
            localparam int unsigned RW = WIDTH - HB;

            logic [HB-1:0] y_q;
            logic [RW-1:0] a_q, b_q, a_up, b_up;
            logic          c_q;
`ifdef CSEL_PIPE_SAT_EN
            logic          sat_q;
`endif

            if (s == 0) begin : g_up
                assign a_up = A[WIDTH-1:HB];
                assign b_up = Sub ? ~B[WIDTH-1:HB] : B[WIDTH-1:HB];
            end else begin : g_up
                assign a_up = stg[s-1].g_reg.a_q[WIDTH-LB-1:SW];
                assign b_up = stg[s-1].g_reg.b_q[WIDTH-LB-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_q   <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                    c_q   <= 1'b0;
`ifdef CSEL_PIPE_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (ld[s] && v_up[s]) begin
                    y_q   <= y_full;
                    a_q   <= a_up;
                    b_q   <= b_up;
                    c_q   <= cc[SG];
`ifdef CSEL_PIPE_SAT_EN
                    sat_q <= sat_s;
`endif
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] y_d, y_q;
            csel_flags_t      f_d, f_q;

            always_comb begin
                y_d      = y_full;
                f_d.cout = cc[SG];
                f_d.ovf  = (a_s[SW-1] == b_s[SW-1]) && (y_full[WIDTH-1] != a_s[SW-1]);
`ifdef CSEL_PIPE_SAT_EN
                if (sat_s && f_d.ovf)
                    y_d = a_s[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
                f_d.zero = (y_d == '0);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_q <= '0;
                    f_q <= '0;
                end else if (ld[s] && v_up[s]) begin
                    y_q <= y_d;
                    f_q <= f_d;
                end
            end

            assign Y    = y_q;
            assign Cout = f_q.cout;
            assign Ovf  = f_q.ovf;
            assign Zero = f_q.zero;
        end
    end

endmodule

// File: tb/tb_csel_pipe_addsub.sv
// Bench for csel_pipe_addsub: 32/4/2 and 64/8/3 instances checked against a queued reference.
module tb_csel_pipe_addsub;

`ifdef CSEL_PIPE_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        iv32 = 1'b0, or32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0, sat32 = 1'b0;
    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] a32 = '0, b32 = '0, y32;
    logic        iv64 = 1'b0, or64 = 1'b0, cin64 = 1'b0, sub64 = 1'b0, sat64 = 1'b0;
    logic        ir64, ov64, co64, of64, z64;
    logic [63:0] a64 = '0, b64 = '0, y64;

    int unsigned n_chk = 0, n_err = 0, n_out32 = 0;
    bit          rnd = 1'b0;
    logic [66:0] q32[$], q64[$];

    always #5 clk = ~clk;

    csel_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
        .Cin(cin32), .Sub(sub32),
`ifdef CSEL_PIPE_SAT_EN
        .Sat(sat32),
`endif
        .out_valid(ov32), .out_ready(or32), .Y(y32), .Cout(co32), .Ovf(of32), .Zero(z32)
    );

    csel_pipe_addsub #(.WIDTH(64), .GROUP(8), .STAGES(3)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
        .Cin(cin64), .Sub(sub64),
`ifdef CSEL_PIPE_SAT_EN
        .Sat(sat64),
`endif
        .out_valid(ov64), .out_ready(or64), .Y(y64), .Cout(co64), .Ovf(of64), .Zero(z64)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] ref_calc(input int unsigned w, input logic [63:0] a,
                                             input logic [63:0] b, input logic cin,
                                             input logic sub, input logic sat);
        logic [63:0] mask, am, be, y;
        logic [64:0] s;
        logic        co, ov, msb;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        be   = (sub ? ~b : b) & mask;
        s    = {1'b0, am} + {1'b0, be} + {64'd0, (sub | cin)};
        y    = s[63:0] & mask;
        co   = s[w];
        msb  = am[w-1];
        ov   = (msb == be[w-1]) && (y[w-1] != msb);
        if (sat && SAT_ON && ov) y = msb ? (64'd1 << (w - 1)) : (mask >> 1);
        return {co, ov, (y == 64'd0), y};
    endfunction

    function automatic logic [66:0] obs32();
        return {co32, of32, z32, 32'h0, y32};
    endfunction

    // Scoreboards: any valid output must match the oldest outstanding beat.
    always @(negedge clk) begin
        if (ov32) begin
            if (q32.size() == 0) chk("spurious32", 67'(ov32), 67'd0);
            else begin
                chk("res32", obs32(), q32[0]);
                if (or32) begin
                    void'(q32.pop_front());
                    n_out32++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov64) begin
            if (q64.size() == 0) chk("spurious64", 67'(ov64), 67'd0);
            else begin
                chk("res64", {co64, of64, z64, y64}, q64[0]);
                if (or64) void'(q64.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit d, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic sat);
        bit done = 1'b0;
        if (!d) begin
            a32 = a[31:0]; b32 = b[31:0]; cin32 = cin; sub32 = sub; sat32 = sat; iv32 = 1'b1;
        end else begin
            a64 = a; b64 = b; cin64 = cin; sub64 = sub; sat64 = sat; iv64 = 1'b1;
        end
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            if (!d && ir32) begin
                q32.push_back(ref_calc(32, a, b, cin, sub, sat));
                done = 1'b1;
            end
            if (d && ir64) begin
                q64.push_back(ref_calc(64, a, b, cin, sub, sat));
                done = 1'b1;
            end
            step();
            if (rnd) begin
                or32 = 1'($urandom_range(0, 1));
                or64 = 1'($urandom_range(0, 1));
            end
        end
        iv32 = 1'b0;
        iv64 = 1'b0;
        chk("accept", 67'(done), 67'd1);
    endtask

    task automatic expect32(input string tag, input logic [66:0] exp);
        @(negedge clk); #1;
        chk({tag, "_lat"}, 67'(ov32), 67'd0);
        @(negedge clk); #1;
        chk({tag, "_valid"}, 67'(ov32), 67'd1);
        chk(tag, obs32(), exp);
        step();
    endtask

    initial begin
        logic [31:0] bpa [4];
        logic [31:0] bpb [4];
        logic [3:0]  bps;
        int unsigned acc, n0, nv;
        bpa = '{32'h7000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678};
        bpb = '{32'h1000_0000, 32'h0000_0002, 32'h0000_0001, 32'h1111_1111};
        bps = 4'b1010;

        #2;
        chk("rst_valid32", 67'(ov32), 67'd0);
        chk("rst_out32", obs32(), 67'd0);
        chk("rst_out64", {co64, of64, z64, y64}, 67'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", 67'(ir32), 67'd1);
        or32 = 1'b1;
        or64 = 1'b1;

        send(0, 64'h0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        expect32("add_carry", {3'b000, 32'h0, 32'h0001_0000});
        send(0, 64'd5, 64'd5, 1'b0, 1'b1, 1'b0);
        expect32("sub_zero", {3'b101, 32'h0, 32'h0});
        send(0, 64'd0, 64'd1, 1'b1, 1'b1, 1'b0);
        expect32("sub_borrow", {3'b000, 32'h0, 32'hFFFF_FFFF});
        send(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
        expect32("ovf_wrap", {3'b010, 32'h0, 32'h8000_0000});
        send(0, 64'hFFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
        expect32("cin_wrap", {3'b101, 32'h0, 32'h0});
`ifdef CSEL_PIPE_SAT_EN
        send(0, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
        expect32("sat_max", {3'b010, 32'h0, 32'h7FFF_FFFF});
        send(0, 64'h8000_0000, 64'd1, 1'b0, 1'b1, 1'b1);
        expect32("sat_min", {3'b110, 32'h0, 32'h8000_0000});
`endif

        // Backpressure: two beats fill the pipe, then in_ready drops and Y holds beat 0.
        or32 = 1'b0;
        acc  = 0;
        for (int c = 0; c < 4; c++) begin
            a32 = bpa[acc]; b32 = bpb[acc]; sub32 = bps[acc]; cin32 = 1'b0; iv32 = 1'b1;
            @(negedge clk);
            if (ir32) begin
                q32.push_back(ref_calc(32, 64'(bpa[acc]), 64'(bpb[acc]), 1'b0, bps[acc], 1'b0));
                acc++;
            end
            step();
        end
        chk("bp_accepts", 67'(acc), 67'd2);
        chk("bp_full_rdy", 67'(ir32), 67'd0);
        chk("bp_hold_y", obs32(), ref_calc(32, 64'(bpa[0]), 64'(bpb[0]), 1'b0, bps[0], 1'b0));
        or32 = 1'b1;
        #1;
        chk("bp_comb_rdy", 67'(ir32), 67'd1);
        n0 = n_out32;
        for (int c = 0; c < 8 && acc < 4; c++) begin
            a32 = bpa[acc]; b32 = bpb[acc]; sub32 = bps[acc]; iv32 = 1'b1;
            @(negedge clk);
            if (ir32) begin
                q32.push_back(ref_calc(32, 64'(bpa[acc]), 64'(bpb[acc]), 1'b0, bps[acc], 1'b0));
                acc++;
            end
            step();
        end
        iv32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("bp_stream4", 67'(n_out32 - n0), 67'd4);
        step();

        // Reset with two beats in flight.
        or32 = 1'b0;
        send(0, 64'd100, 64'd23, 1'b0, 1'b0, 1'b0);
        send(0, 64'd7, 64'd9, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 67'(ov32), 67'd0);
        chk("rst_mid_out", obs32(), 67'd0);
        q32.delete();
        step();
        rst_n = 1'b1;
        or32  = 1'b1;
        nv    = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ov32) nv++;
        end
        chk("no_stale", 67'(nv), 67'd0);
        step();

        rnd = 1'b1;
        for (int i = 0; i < 300; i++)
            send(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rnd  = 1'b0;
        or32 = 1'b1;
        or64 = 1'b1;
        repeat (4) step();

        // 64-bit instance: latency 3 when unstalled, then a randomised stream.
        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        chk("lat64_1", 67'(ov64), 67'd0);
        @(negedge clk); #1;
        chk("lat64_2", 67'(ov64), 67'd0);
        @(negedge clk); #1;
        chk("lat64_3", 67'(ov64), 67'd1);
        chk("wrap64", {co64, of64, z64, y64}, {3'b101, 64'h0});
        step();
        rnd = 1'b1;
        for (int i = 0; i < 2500; i++)
            send(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rnd  = 1'b0;
        or32 = 1'b1;
        or64 = 1'b1;
        repeat (20) step();
        chk("drain32", 67'(q32.size()), 67'd0);
        chk("drain64", 67'(q64.size()), 67'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
